// File: rtl/water_heater_controller.sv
// Drum water heater controller: heats to the latched target, holds it with hysteresis,
// and flags a fault if the target is not reached within the heating time budget.
module water_heater_controller #(
   parameter int unsigned HYST           = 2,
   parameter int unsigned REACH_CYCLES   = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       abort,
   input  logic [5:0] target_temp,
   input  logic [5:0] sensor_temp,
   output logic       heater_on,
   output logic       temp_reached,
   output logic       fault,
   output logic [1:0] state
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_HEAT  = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;
   localparam logic [1:0] ST_FAULT = 2'd3;

   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT_CYCLES);
   localparam logic [3:0]    REACH_DONE = 4'(REACH_CYCLES);
   localparam logic [6:0]    HYST_W     = 7'(HYST);

   logic [1:0]    state_d, state_q;
   logic [5:0]    target_d, target_q;
   logic [TW-1:0] timer_d, timer_q;
   logic [3:0]    reach_d, reach_q;
   logic          heater_on_d, heater_on_q;
   logic          temp_reached_d, temp_reached_q;
   logic          fault_d, fault_q;
   logic          sensor_hit;
   logic [6:0]    hold_thr;

   always_comb begin
      sensor_hit     = (sensor_temp >= target_q);
      // Re-enable threshold saturates at 0 when the target is below the hysteresis band
      hold_thr       = ({1'b0, target_q} >= HYST_W) ? ({1'b0, target_q} - HYST_W) : '0;
      state_d        = state_q;
      target_d       = target_q;
      timer_d        = timer_q;
      reach_d        = reach_q;
      heater_on_d    = heater_on_q;
      if (abort) begin
         state_d     = ST_IDLE;
         timer_d     = '0;
         reach_d     = '0;
         heater_on_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               heater_on_d = 1'b0;
               if (start) begin
                  target_d    = target_temp;
                  timer_d     = '0;
                  reach_d     = '0;
                  state_d     = ST_HEAT;
                  heater_on_d = 1'b1;
               end
            end
            ST_HEAT: begin
               heater_on_d = 1'b1;
               if (timer_q < TIMER_MAX) timer_d = timer_q + TW'(1);
               reach_d = sensor_hit ? (reach_q + 4'd1) : '0;
               // Reaching the target wins over a timeout on the same edge
               if (reach_d == REACH_DONE) begin
                  state_d     = ST_HOLD;
                  heater_on_d = 1'b0;
               end else if (timer_q == TIMER_LAST) begin
                  state_d     = ST_FAULT;
                  heater_on_d = 1'b0;
               end
            end
            ST_HOLD: begin
               if (sensor_hit)                           heater_on_d = 1'b0;
               else if ({1'b0, sensor_temp} <= hold_thr) heater_on_d = 1'b1;
            end
            ST_FAULT: begin
               heater_on_d = 1'b0;
            end
         endcase
      end
      temp_reached_d = (state_d == ST_HOLD);
      fault_d        = (state_d == ST_FAULT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         target_q       <= '0;
         timer_q        <= '0;
         reach_q        <= '0;
         heater_on_q    <= 1'b0;
         temp_reached_q <= 1'b0;
         fault_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         target_q       <= target_d;
         timer_q        <= timer_d;
         reach_q        <= reach_d;
         heater_on_q    <= heater_on_d;
         temp_reached_q <= temp_reached_d;
         fault_q        <= fault_d;
      end
   end

   assign state        = state_q;
   assign heater_on    = heater_on_q;
   assign temp_reached = temp_reached_q;
   assign fault        = fault_q;

endmodule

// File: tb/tb_water_heater_controller.sv
// Bench for water_heater_controller: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the heater rules.
module tb_water_heater_controller;

   localparam int HYST           = 2;
   localparam int REACH_CYCLES   = 4;
   localparam int TIMEOUT_CYCLES = 1000;

   logic       clk = 1'b0;
   logic       reset, start, abort;
   logic [5:0] target_temp, sensor_temp;
   logic       heater_on, temp_reached, fault;
   logic [1:0] state;
   logic [4:0] obs;

   int n_cmp  = 0;
   int n_fail = 0;

   // Behavioural model: mode 0..3, latched target, cycles spent heating, run of hits
   int m_mode, m_target, m_heat_cycles, m_run;
   bit m_heat;

   water_heater_controller #(
      .HYST(HYST), .REACH_CYCLES(REACH_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .target_temp(target_temp), .sensor_temp(sensor_temp),
      .heater_on(heater_on), .temp_reached(temp_reached), .fault(fault), .state(state)
   );

   always #5 clk = ~clk;
   assign obs = {state, heater_on, temp_reached, fault};

   localparam logic [4:0] E_IDLE   = 5'b00_0_0_0;
   localparam logic [4:0] E_HEAT   = 5'b01_1_0_0;
   localparam logic [4:0] E_HOLD0  = 5'b10_0_1_0;
   localparam logic [4:0] E_HOLD1  = 5'b10_1_1_0;
   localparam logic [4:0] E_FAULT  = 5'b11_0_0_1;

   function automatic logic [4:0] model_obs();
      return {2'(m_mode), m_heat, m_mode == 2, m_mode == 3};
   endfunction

   task automatic model_step();
      int thr;
      int elapsed;
      if (reset) begin
         m_mode = 0; m_target = 0; m_heat_cycles = 0; m_run = 0; m_heat = 0;
      end else if (abort) begin
         m_mode = 0; m_heat_cycles = 0; m_run = 0; m_heat = 0;
      end else if (m_mode == 0) begin
         if (start) begin
            m_target = int'(target_temp); m_heat_cycles = 0; m_run = 0;
            m_mode = 1; m_heat = 1;
         end
      end else if (m_mode == 1) begin
         elapsed = m_heat_cycles + 1;
         m_heat_cycles = elapsed;
         m_run = (int'(sensor_temp) >= m_target) ? m_run + 1 : 0;
         if (m_run == REACH_CYCLES) begin
            m_mode = 2; m_heat = 0;
         end else if (elapsed == TIMEOUT_CYCLES) begin
            m_mode = 3; m_heat = 0;
         end
      end else if (m_mode == 2) begin
         thr = m_target - HYST;
         if (thr < 0) thr = 0;
         if (int'(sensor_temp) >= m_target) m_heat = 0;
         else if (int'(sensor_temp) <= thr) m_heat = 1;
      end else begin
         m_heat = 0;
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1; start = 0; abort = 0; target_temp = 6'd0; sensor_temp = 6'd0;
      tick(); tick();
      n_cmp++;
      if (obs !== E_IDLE) begin n_fail++; $display("FAIL reset_state obs=%b exp=%b", obs, E_IDLE); end
      reset = 0;
      tick();
      n_cmp++;
      if (obs !== E_IDLE) begin n_fail++; $display("FAIL reset_release obs=%b exp=%b", obs, E_IDLE); end
   endtask

   task automatic test_nominal();
      target_temp = 6'd40; sensor_temp = 6'd20; start = 1;
      tick(); start = 0;
      n_cmp++;
      if (obs !== E_HEAT) begin n_fail++; $display("FAIL nominal_enter obs=%b exp=%b", obs, E_HEAT); end
      repeat (50) tick();
      sensor_temp = 6'd40;
      repeat (3) tick();
      n_cmp++;
      if (obs !== E_HEAT) begin n_fail++; $display("FAIL nominal_edge3 obs=%b exp=%b", obs, E_HEAT); end
      tick();
      n_cmp++;
      if (obs !== E_HOLD0) begin n_fail++; $display("FAIL nominal_hold obs=%b exp=%b", obs, E_HOLD0); end
      abort = 1; tick(); abort = 0;
   endtask

   task automatic test_noise_filter();
      logic [5:0] seq [7] = '{6'd30, 6'd30, 6'd29, 6'd30, 6'd30, 6'd30, 6'd30};
      target_temp = 6'd30; sensor_temp = 6'd10; start = 1;
      tick(); start = 0;
      for (int i = 0; i < 7; i++) begin
         sensor_temp = seq[i];
         tick();
         n_cmp++;
         if (obs !== ((i == 6) ? E_HOLD0 : E_HEAT)) begin
            n_fail++;
            $display("FAIL noise_step%0d obs=%b exp=%b", i, obs, (i == 6) ? E_HOLD0 : E_HEAT);
         end
      end
      abort = 1; tick(); abort = 0;
   endtask

   task automatic test_hysteresis();
      logic [5:0] seq [4] = '{6'd59, 6'd58, 6'd59, 6'd60};
      logic [4:0] exp [4] = '{E_HOLD0, E_HOLD1, E_HOLD1, E_HOLD0};
      target_temp = 6'd60; sensor_temp = 6'd60; start = 1;
      tick(); start = 0;
      repeat (4) tick();
      for (int i = 0; i < 4; i++) begin
         sensor_temp = seq[i];
         target_temp = 6'd5;
         tick();
         n_cmp++;
         if (obs !== exp[i]) begin n_fail++; $display("FAIL hyst_step%0d obs=%b exp=%b", i, obs, exp[i]); end
      end
      abort = 1; tick(); abort = 0;
   endtask

   task automatic test_timeout();
      target_temp = 6'd60; sensor_temp = 6'd10; start = 1;
      tick(); start = 0;
      repeat (TIMEOUT_CYCLES - 1) tick();
      n_cmp++;
      if (obs !== E_HEAT) begin n_fail++; $display("FAIL timeout_edge999 obs=%b exp=%b", obs, E_HEAT); end
      tick();
      n_cmp++;
      if (obs !== E_FAULT) begin n_fail++; $display("FAIL timeout_fault obs=%b exp=%b", obs, E_FAULT); end
      start = 1; sensor_temp = 6'd63; tick(); start = 0;
      n_cmp++;
      if (obs !== E_FAULT) begin n_fail++; $display("FAIL fault_sticky obs=%b exp=%b", obs, E_FAULT); end
      abort = 1; tick(); abort = 0;
      n_cmp++;
      if (obs !== E_IDLE) begin n_fail++; $display("FAIL fault_abort obs=%b exp=%b", obs, E_IDLE); end
   endtask

   task automatic test_tie();
      target_temp = 6'd50; sensor_temp = 6'd10; start = 1;
      tick(); start = 0;
      repeat (TIMEOUT_CYCLES - REACH_CYCLES) tick();
      sensor_temp = 6'd50;
      repeat (REACH_CYCLES - 1) tick();
      n_cmp++;
      if (obs !== E_HEAT) begin n_fail++; $display("FAIL tie_before obs=%b exp=%b", obs, E_HEAT); end
      tick();
      n_cmp++;
      if (obs !== E_HOLD0) begin n_fail++; $display("FAIL tie_hold obs=%b exp=%b", obs, E_HOLD0); end
      abort = 1; tick(); abort = 0;
   endtask

   task automatic test_abort_reset();
      target_temp = 6'd20; sensor_temp = 6'd0; start = 1; abort = 1;
      tick(); start = 0; abort = 0;
      n_cmp++;
      if (obs !== E_IDLE) begin n_fail++; $display("FAIL abort_start obs=%b exp=%b", obs, E_IDLE); end
      target_temp = 6'd60; sensor_temp = 6'd10; start = 1;
      tick(); start = 0;
      repeat (5) tick();
      abort = 1; tick(); abort = 0;
      n_cmp++;
      if (obs !== E_IDLE) begin n_fail++; $display("FAIL abort_heat obs=%b exp=%b", obs, E_IDLE); end
      target_temp = 6'd0; sensor_temp = 6'd0; start = 1;
      tick(); start = 0;
      repeat (4) tick();
      n_cmp++;
      if (obs !== E_HOLD0) begin n_fail++; $display("FAIL zero_target obs=%b exp=%b", obs, E_HOLD0); end
      abort = 1; tick(); abort = 0;
      target_temp = 6'd60; sensor_temp = 6'd60; start = 1;
      tick(); start = 0;
      repeat (4) tick();
      sensor_temp = 6'd50;
      tick();
      n_cmp++;
      if (obs !== E_HOLD1) begin n_fail++; $display("FAIL hold_heater obs=%b exp=%b", obs, E_HOLD1); end
      reset = 1; tick(); reset = 0;
      n_cmp++;
      if (obs !== E_IDLE) begin n_fail++; $display("FAIL reset_in_hold obs=%b exp=%b", obs, E_IDLE); end
   endtask

   task automatic test_random();
      logic [5:0] temps [6] = '{6'd0, 6'd1, 6'd10, 6'd30, 6'd40, 6'd60};
      int s;
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 299) == 0);
         abort = ($urandom_range(0, 59) == 0);
         start = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 3) == 0)
            target_temp = ($urandom_range(0, 1) == 0) ? temps[$urandom_range(0, 5)] : 6'($urandom);
         if ($urandom_range(0, 9) == 0) begin
            sensor_temp = 6'($urandom);
         end else begin
            s = m_target + $urandom_range(0, 6) - 4;
            if (s < 0) s = 0;
            if (s > 63) s = 63;
            sensor_temp = 6'(s);
         end
         tick();
         n_cmp++;
         if (obs !== model_obs()) begin
            n_fail++;
            $display("FAIL random_cycle%0d obs=%b exp=%b", i, obs, model_obs());
         end
      end
      reset = 0; abort = 0; start = 0;
   endtask

   initial begin
      m_mode = 0; m_target = 0; m_heat_cycles = 0; m_run = 0; m_heat = 0;
      test_reset();
      test_nominal();
      test_noise_filter();
      test_hysteresis();
      test_timeout();
      test_tie();
      test_abort_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
